// File: rtl/glitch_sweep_scheduler.sv
// Glitch sweep scheduler: drives a target through repeated reset/offset/glitch/cool
// attempts and sweeps the glitch offset by a fixed step on each attempt.
// All outputs are registers computed from the next-state decode.
module glitch_sweep_scheduler #(
  parameter int unsigned RST_CYCLES = 10000000,
  parameter int unsigned COOLDOWN   = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [31:0] ofs_start_i,
  input  logic [31:0] ofs_step_i,
  input  logic [15:0] ofs_count_i,
  input  logic [31:0] dur_i,
  output logic        busy_o,
  output logic        target_rst_o,
  output logic        power_ctrl_o,
  output logic [31:0] cur_ofs_o,
  output logic [15:0] attempt_idx_o,
  output logic        attempt_done_o,
  output logic        sweep_done_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RESET  = 3'd1,
    OFFSET = 3'd2,
    GLITCH = 3'd3,
    COOL   = 3'd4
  } state_t;

  // Counters load "length - 1" and leave their phase when they reach zero.
  localparam logic [31:0] RST_LOAD  = 32'(RST_CYCLES - 1);
  localparam logic [31:0] COOL_LOAD = 32'(COOLDOWN - 1);

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] step_q, step_d;
  logic [15:0] count_q, count_d;
  logic [31:0] dur_q, dur_d;
  logic [31:0] cur_ofs_q, cur_ofs_d;
  logic [15:0] idx_q, idx_d;
  logic        busy_q, busy_d;
  logic        target_rst_q, target_rst_d;
  logic        power_ctrl_q, power_ctrl_d;
  logic        attempt_done_q, attempt_done_d;
  logic        sweep_done_q, sweep_done_d;
  logic        empty_sweep;

  // Next-state, counter and latched-parameter logic; output registers follow the next state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    step_d      = step_q;
    count_d     = count_q;
    dur_d       = dur_q;
    cur_ofs_d   = cur_ofs_q;
    idx_d       = idx_q;
    empty_sweep = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i && !abort_i) begin
          if (ofs_count_i != 16'd0) begin
            step_d    = ofs_step_i;
            count_d   = ofs_count_i;
            dur_d     = dur_i;
            cur_ofs_d = ofs_start_i;
            idx_d     = 16'd0;
            cnt_d     = RST_LOAD;
            state_d   = RESET;
          end else begin
            empty_sweep = 1'b1;
          end
        end
      end
      RESET: begin
        if (cnt_q != 32'd0) begin
          cnt_d = cnt_q - 32'd1;
        end else if (cur_ofs_q != 32'd0) begin
          cnt_d   = cur_ofs_q - 32'd1;
          state_d = OFFSET;
        end else if (dur_q != 32'd0) begin
          cnt_d   = dur_q - 32'd1;
          state_d = GLITCH;
        end else begin
          cnt_d   = COOL_LOAD;
          state_d = COOL;
        end
      end
      OFFSET: begin
        if (cnt_q != 32'd0) begin
          cnt_d = cnt_q - 32'd1;
        end else if (dur_q != 32'd0) begin
          cnt_d   = dur_q - 32'd1;
          state_d = GLITCH;
        end else begin
          cnt_d   = COOL_LOAD;
          state_d = COOL;
        end
      end
      GLITCH: begin
        if (cnt_q != 32'd0) begin
          cnt_d = cnt_q - 32'd1;
        end else begin
          cnt_d   = COOL_LOAD;
          state_d = COOL;
        end
      end
      COOL: begin
        if (cnt_q != 32'd0) begin
          cnt_d = cnt_q - 32'd1;
        end else if (idx_q == count_q - 16'd1) begin
          state_d = IDLE;
        end else begin
          cur_ofs_d = cur_ofs_q + step_q;
          idx_d     = idx_q + 16'd1;
          cnt_d     = RST_LOAD;
          state_d   = RESET;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 32'd0;
      end
    endcase

    // Abort overrides everything and produces no completion pulses.
    if (abort_i) begin
      state_d     = IDLE;
      cnt_d       = 32'd0;
      empty_sweep = 1'b0;
    end

    busy_d         = (state_d != IDLE);
    target_rst_d   = (state_d != RESET);
    power_ctrl_d   = (state_d == GLITCH);
    attempt_done_d = (state_d == COOL) && (cnt_d == 32'd0);
    sweep_done_d   = empty_sweep ||
                     (attempt_done_d && (idx_d == count_d - 16'd1));
  end

  // State, counters and registered outputs; reset asynchronously parks the target safely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= 32'd0;
      step_q         <= 32'd0;
      count_q        <= 16'd0;
      dur_q          <= 32'd0;
      cur_ofs_q      <= 32'd0;
      idx_q          <= 16'd0;
      busy_q         <= 1'b0;
      target_rst_q   <= 1'b1;
      power_ctrl_q   <= 1'b0;
      attempt_done_q <= 1'b0;
      sweep_done_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      step_q         <= step_d;
      count_q        <= count_d;
      dur_q          <= dur_d;
      cur_ofs_q      <= cur_ofs_d;
      idx_q          <= idx_d;
      busy_q         <= busy_d;
      target_rst_q   <= target_rst_d;
      power_ctrl_q   <= power_ctrl_d;
      attempt_done_q <= attempt_done_d;
      sweep_done_q   <= sweep_done_d;
    end
  end

  assign busy_o         = busy_q;
  assign target_rst_o   = target_rst_q;
  assign power_ctrl_o   = power_ctrl_q;
  assign cur_ofs_o      = cur_ofs_q;
  assign attempt_idx_o  = idx_q;
  assign attempt_done_o = attempt_done_q;
  assign sweep_done_o   = sweep_done_q;

endmodule

// File: doc/glitch_sweep_scheduler.md
GLITCH_SWEEP_SCHEDULER -- requirements
Module: glitch_sweep_scheduler

Interface
REQ-001 Parameter RST_CYCLES, default 10000000, target reset low-time in clk cycles (100 ms at 100 MHz).
REQ-002 Parameter COOLDOWN, default 1000, idle cycles between attempts.
REQ-003 clk  in  1  system clock, 100 MHz PLL output.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 start  in  1  one-cycle pulse; begins sweep.
REQ-006 abort  in  1  one-cycle pulse; cancels sweep.
REQ-007 ofs_start  in  32  first glitch offset, clk cycles after reset release.
REQ-008 ofs_step  in  32  offset increment per attempt.
REQ-009 ofs_count  in  16  number of attempts.
REQ-010 dur  in  32  glitch width, clk cycles.
REQ-011 busy  out  1  high while not IDLE.
REQ-012 target_rst  out  1  target reset, active-low.
REQ-013 power_ctrl  out  1  high = glitch FET active.
REQ-014 cur_ofs  out  32  offset of current attempt.
REQ-015 attempt_idx  out  16  zero-based index of current attempt.
REQ-016 attempt_done  out  1  one-cycle pulse at end of each attempt.
REQ-017 sweep_done  out  1  one-cycle pulse at sweep completion.

Function
REQ-018 All outputs SHALL be registered; no combinational input-to-output path.
REQ-019 States SHALL be IDLE, RESET, OFFSET, GLITCH, COOL.
REQ-020 In IDLE, start with ofs_count != 0 SHALL latch ofs_start, ofs_step, ofs_count and dur, set cur_ofs=ofs_start and attempt_idx=0, and enter RESET on the next edge.
REQ-021 In IDLE, start with ofs_count == 0 SHALL pulse sweep_done one cycle later and stay in IDLE.
REQ-022 start while busy SHALL be ignored; input changes after latching SHALL have no effect until the next start.
REQ-023 RESET SHALL drive target_rst=0 for exactly RST_CYCLES cycles, then enter OFFSET.
REQ-024 OFFSET SHALL hold target_rst=1 and power_ctrl=0 for exactly cur_ofs cycles; cur_ofs=0 SHALL enter GLITCH directly, so power_ctrl rises on the first cycle after target_rst rises.
REQ-025 GLITCH SHALL drive power_ctrl=1 for exactly dur cycles; dur=0 SHALL skip GLITCH with no power_ctrl pulse.
REQ-026 COOL SHALL last COOLDOWN cycles; attempt_done SHALL pulse in the last COOL cycle.
REQ-027 On COOL exit, if attempt_idx == latched ofs_count-1, sweep_done SHALL pulse and the state SHALL enter IDLE in the same cycle; otherwise cur_ofs += ofs_step (mod 2^32, wrap silent), attempt_idx += 1, and the state SHALL enter RESET.
REQ-028 Counters SHALL be 32 bits; maximum-value offset/dur (2^32-1) SHALL count fully without overflow.
REQ-029 abort in any state SHALL force IDLE, power_ctrl=0 and target_rst=1 on the next edge, with no attempt_done or sweep_done pulse.
REQ-030 start and abort in the same IDLE cycle: abort wins, no sweep starts.
REQ-031 power_ctrl=1 SHALL only occur in GLITCH and never while target_rst=0.

Reset
REQ-032 rst_n low SHALL asynchronously force IDLE, busy=0, target_rst=1, power_ctrl=0, cur_ofs=0, attempt_idx=0, attempt_done=0, sweep_done=0.
REQ-033 rst_n low mid-GLITCH SHALL drop power_ctrl immediately, without waiting for clk.
REQ-034 First start SHALL be accepted on the first clk edge after rst_n deasserts.

Verification (RST_CYCLES=4, COOLDOWN=2)
REQ-035 start, ofs_start=3, dur=2, count=1 -> target_rst low 4 cycles; power_ctrl high 2 cycles beginning 3 cycles after target_rst rises; attempt_done and sweep_done pulse together; busy falls.
REQ-036 ofs_start=0, step=5, count=3, dur=1 -> attempts at cur_ofs 0, 5, 10; three attempt_done pulses; sweep_done after the third; attempt_idx ends at 2.
REQ-037 dur=0, count=2 -> power_ctrl never asserts; two attempt_done pulses; sweep_done.
REQ-038 abort during GLITCH -> power_ctrl=0 and target_rst=1 next cycle; busy=0; no done pulses; a new start works normally.
REQ-039 ofs_start=FFFFFFFE, step=3, count=2 -> second attempt uses cur_ofs=1.
REQ-040 rst_n asserted mid-RESET -> target_rst=1 and power_ctrl=0 immediately; second start while busy ignored; count=0 start -> sweep_done only.
